// File: rtl/mem_load_store_unit_if.sv
// mem_load_store_unit_if
// Bundles the core-side request/response handshake and the memory port of
// the load/store unit.
//   core request : req_valid, req_ready, req_write, req_size, req_signed,
//                  req_addr, req_wdata
//   core response: resp_valid, resp_fault, resp_rdata
//   memory port  : mem_addr, mem_w_en, mem_w_data, mem_r_data (the read
//                  window is combinational from mem_addr)
// Modports:
//   slave  - the load/store unit itself
//   master - the environment around it (core plus memory)

interface mem_load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_w_en;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_r_data,
    output req_ready, resp_valid, resp_fault, resp_rdata,
    output mem_addr, mem_w_en, mem_w_data
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_r_data,
    input  req_ready, resp_valid, resp_fault, resp_rdata,
    input  mem_addr, mem_w_en, mem_w_data
  );
endinterface

// File: rtl/mem_load_store_unit.sv
// mem_load_store_unit
// CPU-side initiator for a byte-addressed, little-endian 32-bit memory port.
// It accepts one load/store at a time, checks size/alignment/address range,
// and performs byte, halfword or word accesses. Sub-word stores use a
// read-modify-write of the 4-byte window starting at the request address.
//
// Ports:
//   clk  - system clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_load_store_unit_if.slave (request, response and memory port)
//
// Parameters:
//   ADDR_LIMIT - highest valid byte address
//   ROM_END    - highest ROM byte address (only with LSU_ROM_WP_EN)
//
// Optional feature, macro LSU_ROM_WP_EN: when defined, any store whose first
// byte address is <= ROM_END is rejected with a fault and no memory cycle.

module mem_load_store_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0003FFFF,
  parameter logic [31:0] ROM_END    = 32'h0001FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_load_store_unit_if.slave  bus
);

`ifdef LSU_ROM_WP_EN
  localparam logic WP_EN = 1'b1;
`else
  localparam logic WP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        accept_s;
  logic        fault_s;
  logic [1:0]  size_r;
  logic        signed_r;

  logic [31:0] mem_addr_r;
  logic [31:0] mem_addr_nxt_s;
  logic        mem_w_en_r;
  logic        mem_w_en_nxt_s;
  logic [31:0] mem_w_data_r;
  logic [31:0] mem_w_data_nxt_s;
  logic        resp_valid_r;
  logic        resp_valid_nxt_s;
  logic        resp_fault_r;
  logic        resp_fault_nxt_s;
  logic [31:0] resp_rdata_r;
  logic [31:0] resp_rdata_nxt_s;

  // Access legality. Sums are 33 bits wide so a wrap past 0xFFFFFFFF is
  // seen as out of range. Sub-word stores touch a full 4-byte window
  // during the read-modify-write, so that window must be in range too.
  function automatic logic check_fault(input logic        write,
                                       input logic [1:0]  size,
                                       input logic [31:0] addr);
    logic [32:0] last_v;
    logic [32:0] win_v;
    logic        f_v;
    last_v = {1'b0, addr};
    win_v  = {1'b0, addr} + 33'd3;
    case (size)
      2'b00: begin
        last_v = {1'b0, addr};
        f_v    = write & (win_v > {1'b0, ADDR_LIMIT});
      end
      2'b01: begin
        last_v = {1'b0, addr} + 33'd1;
        f_v    = addr[0] | (write & (win_v > {1'b0, ADDR_LIMIT}));
      end
      2'b10: begin
        last_v = {1'b0, addr} + 33'd3;
        f_v    = (addr[1:0] != 2'b00);
      end
      default: begin
        f_v = 1'b1;
      end
    endcase
    if (last_v > {1'b0, ADDR_LIMIT}) begin
      f_v = 1'b1;
    end else begin
      f_v = f_v;
    end
    if (WP_EN && write && (addr <= ROM_END)) begin
      f_v = 1'b1;
    end else begin
      f_v = f_v;
    end
    return f_v;
  endfunction

  // Pick the loaded lane out of the read window and extend it.
  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic        sgn,
                                              input logic [31:0] raw);
    case (size)
      2'b00:   return {{24{sgn & raw[7]}}, raw[7:0]};
      2'b01:   return {{16{sgn & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Replace the low lane(s) of the read window; upper bytes are rewritten.
  function automatic logic [31:0] rmw_merge(input logic [1:0]  size,
                                            input logic [31:0] old,
                                            input logic [31:0] wdata);
    case (size)
      2'b00:   return {old[31:8], wdata[7:0]};
      2'b01:   return {old[31:16], wdata[15:0]};
      default: return wdata;
    endcase
  endfunction

  assign bus.req_ready  = (state_r == IDLE);
  assign accept_s       = (state_r == IDLE) & bus.req_valid;
  assign fault_s        = check_fault(bus.req_write, bus.req_size, bus.req_addr);

  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_w_en   = mem_w_en_r;
  assign bus.mem_w_data = mem_w_data_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_fault = resp_fault_r;
  assign bus.resp_rdata = resp_rdata_r;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_nxt_s = IDLE;
        end else if (fault_s) begin
          state_nxt_s = RESP;
        end else if (!bus.req_write) begin
          state_nxt_s = LOAD;
        end else if (bus.req_size == 2'b10) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = RMW_RD;
        end
      end
      LOAD:    state_nxt_s = RESP;
      RMW_RD:  state_nxt_s = WRITE;
      WRITE:   state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs. Strobes look
  // ahead at the next state so they are high exactly while in that state.
  always_comb begin
    mem_addr_nxt_s   = mem_addr_r;
    mem_w_data_nxt_s = mem_w_data_r;
    mem_w_en_nxt_s   = (state_nxt_s == WRITE);
    resp_valid_nxt_s = (state_nxt_s == RESP);
    resp_fault_nxt_s = 1'b0;
    resp_rdata_nxt_s = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        resp_fault_nxt_s = accept_s & fault_s;
        if (accept_s && !fault_s) begin
          mem_addr_nxt_s   = bus.req_addr;
          mem_w_data_nxt_s = bus.req_wdata;
        end else begin
          mem_addr_nxt_s   = mem_addr_r;
          mem_w_data_nxt_s = mem_w_data_r;
        end
      end
      LOAD: begin
        resp_rdata_nxt_s = load_extend(size_r, signed_r, bus.mem_r_data);
      end
      RMW_RD: begin
        // mem_w_data_r still holds the right-aligned store data here.
        mem_w_data_nxt_s = rmw_merge(size_r, bus.mem_r_data, mem_w_data_r);
      end
      default: begin
        resp_fault_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered outputs; async reset drops mem_w_en without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_r   <= 32'h0000_0000;
      mem_w_en_r   <= 1'b0;
      mem_w_data_r <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      resp_fault_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      mem_addr_r   <= mem_addr_nxt_s;
      mem_w_en_r   <= mem_w_en_nxt_s;
      mem_w_data_r <= mem_w_data_nxt_s;
      resp_valid_r <= resp_valid_nxt_s;
      resp_fault_r <= resp_fault_nxt_s;
      resp_rdata_r <= resp_rdata_nxt_s;
    end
  end

  // Request fields needed after the accept cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_r   <= 2'b00;
      signed_r <= 1'b0;
    end else if (accept_s) begin
      size_r   <= bus.req_size;
      signed_r <= bus.req_signed;
    end
  end

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Self-checking bench for mem_load_store_unit: byte-array memory behind the
// port, byte-level reference model, scoreboard queue and response monitor.
module tb_mem_load_store_unit;
  localparam logic [31:0] ADDR_LIMIT = 32'h0003FFFF;
  localparam logic [31:0] ROM_END    = 32'h0001FFFF;
  localparam int          MEM_BYTES  = 32'h00040000;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   neg_cnt = 0;
  int   wcnt = 0;
  int unsigned wr_gen = 0;

  mem_load_store_unit_if bus();

  mem_load_store_unit #(.ADDR_LIMIT(ADDR_LIMIT), .ROM_END(ROM_END)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT, and the reference model's own copy.
  logic [7:0] phys    [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];

  typedef struct {
    bit          fault;
    logic [31:0] rdata;
    int          due;
    int          writes;
  } exp_t;
  exp_t sb_q[$];

  function automatic logic [7:0] rd_byte(input longint a);
    if (a <= longint'(ADDR_LIMIT)) return phys[a];
    return 8'h00;
  endfunction

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) phys[i] <= 8'h00;
  end

  // Combinational read window, refreshed on address change or any write.
  always @(bus.mem_addr or wr_gen) begin
    bus.mem_r_data = {rd_byte(longint'(bus.mem_addr) + 3), rd_byte(longint'(bus.mem_addr) + 2),
                      rd_byte(longint'(bus.mem_addr) + 1), rd_byte(longint'(bus.mem_addr))};
  end

  // Memory commits writes on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_w_en) begin
      for (int i = 0; i < 4; i++) begin
        if (longint'(bus.mem_addr) + i <= longint'(ADDR_LIMIT))
          phys[longint'(bus.mem_addr) + i] <= bus.mem_w_data[8*i +: 8];
      end
      wr_gen <= wr_gen + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (rst) begin
        wcnt = 0;
      end else begin
        if (bus.mem_w_en) wcnt++;
        if (bus.resp_valid) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp: resp_valid with nothing outstanding at cycle %0d", neg_cnt);
          end else begin
            e = sb_q.pop_front();
            check("resp_fault", 32'(bus.resp_fault), 32'(e.fault));
            check("resp_rdata", bus.resp_rdata, e.rdata);
            check("latency_cycle", 32'(neg_cnt), 32'(e.due));
            check("write_pulses", 32'(wcnt), 32'(e.writes));
          end
          wcnt = 0;
        end
      end
    end
  end

  // Waits (bounded) for req_ready, half a cycle before a rising edge.
  task automatic wait_ready(output bit ok);
    int waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (!bus.req_ready && waited < 50);
    ok = bus.req_ready;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: req_ready=%0b after %0d cycles, expected 1", bus.req_ready, waited);
    end
  endtask

  // Issues one request and pushes the model's expected response.
  task automatic issue(input bit wr, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bit     ok;
    int     nbytes;
    longint a;
    longint v;
    exp_t   e;
    wait_ready(ok);
    if (!ok) return;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a = longint'(addr);
    e.fault = (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) ||
              (size == 2'd2 && (a % 4) != 0) ||
              (a + nbytes - 1 > longint'(ADDR_LIMIT)) ||
              (wr && size != 2'd2 && a + 3 > longint'(ADDR_LIMIT));
`ifdef LSU_ROM_WP_EN
    if (wr && a <= longint'(ROM_END)) e.fault = 1'b1;
`endif
    e.rdata  = 32'h0;
    e.writes = 0;
    if (e.fault) begin
      e.due = neg_cnt + 1;
    end else if (wr) begin
      for (int i = 0; i < nbytes; i++) ref_mem[a + i] = wdata[8*i +: 8];
      e.due    = neg_cnt + ((nbytes == 4) ? 2 : 3);
      e.writes = 1;
    end else begin
      v = 0;
      for (int i = 0; i < nbytes; i++) v = v + (longint'(ref_mem[a + i]) << (8 * i));
      if (sgn && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
        v = v - (longint'(1) << (8 * nbytes));
      e.rdata = v[31:0];
      e.due   = neg_cnt + 2;
    end
    bus.req_write  = wr;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    // Scramble fields: the unit must have captured them already.
    bus.req_write  = $urandom_range(0, 1) != 0;
    bus.req_size   = 2'($urandom_range(0, 3));
    bus.req_signed = $urandom_range(0, 1) != 0;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  initial begin
    bit          ok;
    int          waited;
    int          c;
    logic [1:0]  sz;
    logic [31:0] ad;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mem_w_en", 32'(bus.mem_w_en), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_w_data", bus.mem_w_data, 32'h0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    rst = 1'b0;

    // Word store / load round trip.
    issue(1'b1, 2'd2, 1'b0, 32'h0002_0000, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h0002_0000, 32'h0);
    // Sub-word RMW store keeps the neighbouring bytes.
    issue(1'b1, 2'd2, 1'b0, 32'h0002_0000, 32'h1122_3344);
    issue(1'b1, 2'd0, 1'b0, 32'h0002_0001, 32'h0000_005A);
    issue(1'b0, 2'd2, 1'b0, 32'h0002_0000, 32'h0);
    // Sign and zero extension.
    issue(1'b1, 2'd0, 1'b0, 32'h0002_0010, 32'h0000_00F0);
    issue(1'b0, 2'd0, 1'b1, 32'h0002_0010, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h0002_0010, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h0002_0010, 32'h0000_8001);
    issue(1'b0, 2'd1, 1'b1, 32'h0002_0010, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h0002_0010, 32'h0);
    issue(1'b0, 2'd2, 1'b1, 32'h0002_0000, 32'h0);
    // Faults: alignment, reserved size, range, window, wrap.
    issue(1'b0, 2'd2, 1'b0, 32'h0002_0002, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h0002_0001, 32'h0000_1234);
    issue(1'b0, 2'd3, 1'b0, 32'h0002_0000, 32'h0);
    issue(1'b0, 2'd2, 1'b0, ADDR_LIMIT - 32'd1, 32'h0);
    issue(1'b0, 2'd1, 1'b0, ADDR_LIMIT, 32'h0);
    issue(1'b1, 2'd0, 1'b0, ADDR_LIMIT - 32'd2, 32'h0000_0077);
    issue(1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0);
    // Range edges that are legal.
    issue(1'b1, 2'd2, 1'b0, ADDR_LIMIT - 32'd3, 32'hA5A5_0F0F);
    issue(1'b1, 2'd0, 1'b0, ADDR_LIMIT - 32'd3, 32'h0000_0033);
    issue(1'b0, 2'd0, 1'b0, ADDR_LIMIT, 32'h0);
    issue(1'b0, 2'd2, 1'b0, ADDR_LIMIT - 32'd3, 32'h0);
    // ROM region store (faults only with write protection).
    issue(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hCAFE_F00D);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);

    // Reset in the WRITE state of a byte store: nothing must be written.
    wait_ready(ok);
    if (ok) begin
      bus.req_write  = 1'b1;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h0002_0020;
      bus.req_wdata  = 32'h0000_00AB;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rmw_write_en", 32'(bus.mem_w_en), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_drops_w_en", 32'(bus.mem_w_en), 32'd0);
      check("rst_no_resp", 32'(bus.resp_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(bus.req_ready), 32'd1);
      issue(1'b0, 2'd2, 1'b0, 32'h0002_0020, 32'h0);
    end

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      c  = $urandom_range(0, 7);
      sz = (c < 7) ? 2'(c % 3) : 2'd3;
      c  = $urandom_range(0, 9);
      if (c <= 6)      ad = 32'h0002_0000 + 32'($urandom_range(0, 63));
      else if (c == 7) ad = ADDR_LIMIT - 32'($urandom_range(0, 5));
      else if (c == 8) ad = 32'h0000_0100 + 32'($urandom_range(0, 15));
      else             ad = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3)
        ad = ad & ~((sz == 2'd0) ? 32'd0 : (sz == 2'd1) ? 32'd1 : 32'd3);
      issue($urandom_range(0, 1) != 0, sz, $urandom_range(0, 1) != 0, ad, $urandom);
    end

    waited = 0;
    while (sb_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    check("drain_outstanding", 32'(sb_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
